uart_engine: RTL and testbench

Single-clock, parametrised UART core. It is the successor of the current UART datapath and replaces the derived baud clocks and CDC FIFOs with a fractional-free tick enable and synchronous FIFOs. It provides runtime-selectable 5–8 data bits, a configurable oversampling factor and FIFO depth, and framing/overrun detection. The block sits behind the UART register interface, which drives the cfg_* inputs and the FIFO handshakes.

---
 rtl/uart_engine.sv | 395 +++++++++++++++++++++++++++++++++++++++
 tb/tb_uart_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_engine.sv
// UART engine: single-clock UART core with tick-enable baud timing and synchronous TX/RX FIFOs.
// Optional build macro UART_ENGINE_MAJORITY_EN selects 3-sample majority voting on RX bits.
// Clock clk_i, asynchronous active-low reset arst_ni.

// Generic synchronous FIFO with registered storage and occupancy count.
// Latency: a pushed entry is visible at rd_dat / counted one cycle after the push edge.
// Backpressure: wr_rdy is low only when full; flush clears pointers and count and wins over push/pop.
module uart_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic                         flush,
    input  logic                         wr_vld,
    output logic                         wr_rdy,
    input  logic [W-1:0]                 wr_dat,
    output logic                         rd_vld,
    input  logic                         rd_rdy,
    output logic [W-1:0]                 rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;

    assign wr_rdy = (cnt != CW'(DEPTH));
    assign rd_vld = (cnt != '0);
    assign push   = wr_vld & wr_rdy;
    assign pop    = rd_rdy & rd_vld;
    assign rd_dat = mem[rd_ptr];
    assign count  = cnt;

    // Storage, pointers (wrap modulo DEPTH) and occupancy; flush overrides traffic.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end
endmodule

// UART engine top: TX/RX FIFOs, tick generator, TX and RX frame FSMs.
// Latency: TX frame starts on the first tick after a byte is queued; RX byte lands one cycle after the mid-stop decision.
// Backpressure: tx_ready_o drops when TX FIFO is full; a full RX FIFO drops the new byte and flags overrun.
module uart_engine #(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                              clk_i,
    input  logic                              arst_ni,
    input  logic [DIV_WIDTH-1:0]              cfg_div_i,
    input  logic [1:0]                        cfg_data_bits_i,
    input  logic                              cfg_parity_en_i,
    input  logic                              cfg_parity_type_i,
    input  logic                              cfg_stop_bits_i,
    input  logic                              tx_flush_i,
    input  logic                              rx_flush_i,
    input  logic [7:0]                        tx_data_i,
    input  logic                              tx_valid_i,
    output logic                              tx_ready_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   tx_count_o,
    output logic                              tx_busy_o,
    output logic [7:0]                        rx_data_o,
    output logic                              rx_valid_o,
    input  logic                              rx_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_count_o,
    output logic                              rx_parity_err_o,
    output logic                              rx_frame_err_o,
    output logic                              rx_overrun_o,
    output logic                              tx_o,
    input  logic                              rx_i
);
    localparam int OW = $clog2(OVERSAMPLE);

    // ---------------- tick generator ----------------
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    assign tick = (div_cnt == cfg_div_i);

    // Counter wraps when it reaches (or has overshot after a divisor change) the divisor.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)                div_cnt <= '0;
        else if (div_cnt >= cfg_div_i) div_cnt <= '0;
        else                         div_cnt <= div_cnt + 1'b1;
    end

    // ---------------- FIFOs ----------------
    logic       tx_fifo_vld;
    logic [7:0] tx_fifo_dat;
    logic       tx_pop;
    logic       rx_push;
    logic       rx_wr_rdy;
    logic [7:0] rx_shift;

    uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_tx_fifo (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .flush  (tx_flush_i),
        .wr_vld (tx_valid_i),
        .wr_rdy (tx_ready_o),
        .wr_dat (tx_data_i),
        .rd_vld (tx_fifo_vld),
        .rd_rdy (tx_pop),
        .rd_dat (tx_fifo_dat),
        .count  (tx_count_o)
    );

    uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_rx_fifo (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .flush  (rx_flush_i),
        .wr_vld (rx_push),
        .wr_rdy (rx_wr_rdy),
        .wr_dat (rx_shift),
        .rd_vld (rx_valid_o),
        .rd_rdy (rx_ready_i),
        .rd_dat (rx_data_o),
        .count  (rx_count_o)
    );

    // ---------------- TX ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t     tx_state, tx_state_d;
    logic [OW-1:0] tx_oc, tx_oc_d;
    logic [2:0]    tx_bit, tx_bit_d;
    logic [7:0]    tx_byte, tx_byte_d;
    logic [2:0]    tx_nbits, tx_nbits_d;      // data bits minus one
    logic          tx_par_en, tx_par_en_d;
    logic          tx_par_type, tx_par_type_d;
    logic          tx_stop2, tx_stop2_d;
    logic          tx_stop_idx, tx_stop_idx_d;
    logic          tx_o_d;
    logic          tx_bit_end;
    logic          tx_par_bit;

    assign tx_bit_end = tick && (tx_oc == OW'(OVERSAMPLE-1));
    assign tx_busy_o  = (tx_state != TX_IDLE);

    // TX frame sequencing; the line level is derived from the next state so tx_o is a flop.
    always_comb begin
        tx_state_d    = tx_state;
        tx_oc_d       = tx_oc;
        tx_bit_d      = tx_bit;
        tx_byte_d     = tx_byte;
        tx_nbits_d    = tx_nbits;
        tx_par_en_d   = tx_par_en;
        tx_par_type_d = tx_par_type;
        tx_stop2_d    = tx_stop2;
        tx_stop_idx_d = tx_stop_idx;
        tx_pop        = 1'b0;
        tx_o_d        = 1'b1;
        if (tx_state != TX_IDLE && tick) tx_oc_d = tx_bit_end ? '0 : tx_oc + 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (tick && tx_fifo_vld) begin
                    tx_pop        = 1'b1;
                    tx_state_d    = TX_START;
                    tx_oc_d       = '0;
                    tx_byte_d     = tx_fifo_dat;
                    tx_nbits_d    = 3'(cfg_data_bits_i) + 3'd4;
                    tx_par_en_d   = cfg_parity_en_i;
                    tx_par_type_d = cfg_parity_type_i;
                    tx_stop2_d    = cfg_stop_bits_i;
                    tx_stop_idx_d = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit == tx_nbits) tx_state_d = tx_par_en ? TX_PARITY : TX_STOP;
                    else                    tx_bit_d   = tx_bit + 1'b1;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_stop2 && !tx_stop_idx) tx_stop_idx_d = 1'b1;
                    else                          tx_state_d    = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        tx_par_bit = (^(tx_byte_d & (8'hFF >> (3'd7 - tx_nbits_d)))) ^ tx_par_type_d;
        case (tx_state_d)
            TX_START:  tx_o_d = 1'b0;
            TX_DATA:   tx_o_d = tx_byte_d[tx_bit_d];
            TX_PARITY: tx_o_d = tx_par_bit;
            default:   tx_o_d = 1'b1;
        endcase
    end

    // TX state registers; reset forces the line idle high at once.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            tx_state    <= TX_IDLE;
            tx_oc       <= '0;
            tx_bit      <= '0;
            tx_byte     <= '0;
            tx_nbits    <= '0;
            tx_par_en   <= 1'b0;
            tx_par_type <= 1'b0;
            tx_stop2    <= 1'b0;
            tx_stop_idx <= 1'b0;
            tx_o        <= 1'b1;
        end else begin
            tx_state    <= tx_state_d;
            tx_oc       <= tx_oc_d;
            tx_bit      <= tx_bit_d;
            tx_byte     <= tx_byte_d;
            tx_nbits    <= tx_nbits_d;
            tx_par_en   <= tx_par_en_d;
            tx_par_type <= tx_par_type_d;
            tx_stop2    <= tx_stop2_d;
            tx_stop_idx <= tx_stop_idx_d;
            tx_o        <= tx_o_d;
        end
    end

    // ---------------- RX ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

    rx_state_t     rx_state, rx_state_d;
    logic [OW-1:0] rx_oc, rx_oc_d;
    logic [2:0]    rx_bit, rx_bit_d;
    logic [7:0]    rx_shift_d;
    logic [2:0]    rx_nbits, rx_nbits_d;
    logic          rx_par_en, rx_par_en_d;
    logic          rx_par_type, rx_par_type_d;
    logic          rx_par_bad, rx_par_bad_d;
    logic          rx_meta, rx_sync;
    logic          smp_mid;
    logic          rx_bit_val;
    logic          rx_dec;
    logic          rx_bit_end;
    logic          rx_frame_bad;

    // Two-flop synchroniser for the asynchronous serial input, idling high.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

`ifdef UART_ENGINE_MAJORITY_EN
    logic smp_early;
    // Capture the samples either side of mid-bit; the third is the live value one tick later.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            smp_early <= 1'b1;
            smp_mid   <= 1'b1;
        end else if (tick) begin
            if (rx_oc == OW'(OVERSAMPLE/2-1)) smp_early <= rx_sync;
            if (rx_oc == OW'(OVERSAMPLE/2))   smp_mid   <= rx_sync;
        end
    end
    assign rx_bit_val = (smp_early & smp_mid) | (smp_early & rx_sync) | (smp_mid & rx_sync);
`else
    // Capture the mid-bit sample; decisions still happen one tick later so both builds time alike.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni)                                smp_mid <= 1'b1;
        else if (tick && rx_oc == OW'(OVERSAMPLE/2)) smp_mid <= rx_sync;
    end
    assign rx_bit_val = smp_mid;
`endif

    assign rx_dec     = tick && (rx_oc == OW'(OVERSAMPLE/2+1));
    assign rx_bit_end = tick && (rx_oc == OW'(OVERSAMPLE-1));

    // RX frame sequencing; the detection tick counts as tick 0 of the start bit.
    always_comb begin
        rx_state_d    = rx_state;
        rx_oc_d       = rx_oc;
        rx_bit_d      = rx_bit;
        rx_shift_d    = rx_shift;
        rx_nbits_d    = rx_nbits;
        rx_par_en_d   = rx_par_en;
        rx_par_type_d = rx_par_type;
        rx_par_bad_d  = rx_par_bad;
        rx_push       = 1'b0;
        rx_frame_bad  = 1'b0;
        if (rx_state != RX_IDLE && rx_state != RX_WAIT_IDLE && tick)
            rx_oc_d = rx_bit_end ? '0 : rx_oc + 1'b1;
        case (rx_state)
            RX_IDLE: begin
                if (tick && !rx_sync) begin
                    rx_state_d    = RX_START;
                    rx_oc_d       = OW'(1);
                    rx_bit_d      = '0;
                    rx_shift_d    = '0;
                    rx_par_bad_d  = 1'b0;
                    rx_nbits_d    = 3'(cfg_data_bits_i) + 3'd4;
                    rx_par_en_d   = cfg_parity_en_i;
                    rx_par_type_d = cfg_parity_type_i;
                end
            end
            RX_START: begin
                if (rx_dec && rx_bit_val) rx_state_d = RX_IDLE;
                else if (rx_bit_end) begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_dec) rx_shift_d[rx_bit] = rx_bit_val;
                if (rx_bit_end) begin
                    if (rx_bit == rx_nbits) rx_state_d = rx_par_en ? RX_PARITY : RX_STOP;
                    else                    rx_bit_d   = rx_bit + 1'b1;
                end
            end
            RX_PARITY: begin
                if (rx_dec) rx_par_bad_d = rx_bit_val ^ (^rx_shift) ^ rx_par_type;
                if (rx_bit_end) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (rx_dec) begin
                    if (rx_bit_val) begin
                        rx_push    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_frame_bad = 1'b1;
                        rx_state_d   = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (tick && rx_sync) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state registers and one-cycle error pulses.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rx_state        <= RX_IDLE;
            rx_oc           <= '0;
            rx_bit          <= '0;
            rx_shift        <= '0;
            rx_nbits        <= '0;
            rx_par_en       <= 1'b0;
            rx_par_type     <= 1'b0;
            rx_par_bad      <= 1'b0;
            rx_parity_err_o <= 1'b0;
            rx_frame_err_o  <= 1'b0;
            rx_overrun_o    <= 1'b0;
        end else begin
            rx_state        <= rx_state_d;
            rx_oc           <= rx_oc_d;
            rx_bit          <= rx_bit_d;
            rx_shift        <= rx_shift_d;
            rx_nbits        <= rx_nbits_d;
            rx_par_en       <= rx_par_en_d;
            rx_par_type     <= rx_par_type_d;
            rx_par_bad      <= rx_par_bad_d;
            rx_parity_err_o <= rx_push & rx_par_bad;
            rx_frame_err_o  <= rx_frame_bad;
            rx_overrun_o    <= rx_push & ~rx_wr_rdy;
        end
    end
endmodule

// File: tb/tb_uart_engine.sv
// Directed bench for uart_engine: reset state, TX waveform, loopback, RX error paths, overrun, TX flush, glitch.
// Expected values are hand-derived constants; each comparison is an immediate assertion.
// Error pulses are counted on every falling edge so pulse width is checked via the counts.
module tb_uart_engine;
    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic [15:0] cfg_div_i = '0;
    logic [1:0]  cfg_data_bits_i = 2'd3;
    logic        cfg_parity_en_i = 1'b0;
    logic        cfg_parity_type_i = 1'b0;
    logic        cfg_stop_bits_i = 1'b0;
    logic        tx_flush_i = 1'b0;
    logic        rx_flush_i = 1'b0;
    logic [7:0]  tx_data_i = '0;
    logic        tx_valid_i = 1'b0;
    logic        tx_ready_o;
    logic [4:0]  tx_count_o;
    logic        tx_busy_o;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i = 1'b0;
    logic [4:0]  rx_count_o;
    logic        rx_parity_err_o;
    logic        rx_frame_err_o;
    logic        rx_overrun_o;
    logic        tx_o;
    logic        rx_line;
    logic        rx_drv = 1'b1;
    logic        loop_en = 1'b0;

    int total = 0;
    int bad = 0;
    int par_cnt = 0;
    int frm_cnt = 0;
    int ovr_cnt = 0;

    assign rx_line = loop_en ? tx_o : rx_drv;

    always #5 clk_i = ~clk_i;

    uart_engine dut (
        .clk_i            (clk_i),
        .arst_ni          (arst_ni),
        .cfg_div_i        (cfg_div_i),
        .cfg_data_bits_i  (cfg_data_bits_i),
        .cfg_parity_en_i  (cfg_parity_en_i),
        .cfg_parity_type_i(cfg_parity_type_i),
        .cfg_stop_bits_i  (cfg_stop_bits_i),
        .tx_flush_i       (tx_flush_i),
        .rx_flush_i       (rx_flush_i),
        .tx_data_i        (tx_data_i),
        .tx_valid_i       (tx_valid_i),
        .tx_ready_o       (tx_ready_o),
        .tx_count_o       (tx_count_o),
        .tx_busy_o        (tx_busy_o),
        .rx_data_o        (rx_data_o),
        .rx_valid_o       (rx_valid_o),
        .rx_ready_i       (rx_ready_i),
        .rx_count_o       (rx_count_o),
        .rx_parity_err_o  (rx_parity_err_o),
        .rx_frame_err_o   (rx_frame_err_o),
        .rx_overrun_o     (rx_overrun_o),
        .tx_o             (tx_o),
        .rx_i             (rx_line)
    );

    always @(negedge clk_i) begin
        if (rx_parity_err_o) par_cnt++;
        if (rx_frame_err_o)  frm_cnt++;
        if (rx_overrun_o)    ovr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Bit-bang one frame on rx_drv; the line is left at stop_val.
    task automatic send_frame(input logic [7:0] b, input int nb, input bit par_en,
                              input bit par_val, input bit stop_val, input int bitc);
        rx_drv = 1'b0;
        cycles(bitc);
        for (int i = 0; i < nb; i++) begin
            rx_drv = b[i];
            cycles(bitc);
        end
        if (par_en) begin
            rx_drv = par_val;
            cycles(bitc);
        end
        rx_drv = stop_val;
        cycles(bitc);
    endtask

    task automatic pop_rx();
        rx_ready_i = 1'b1;
        cycles(1);
        rx_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] pat;

        // ---- reset state ----
        cycles(3);
        check("rst_tx_o", tx_o, 1);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_tx_busy", tx_busy_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_data", rx_data_o, 8'h00);
        check("rst_tx_count", tx_count_o, 0);
        check("rst_rx_count", rx_count_o, 0);
        check("rst_pulses", {rx_parity_err_o, rx_frame_err_o, rx_overrun_o}, 3'b000);
        arst_ni = 1'b1;
        cycles(3);

        // ---- TX waveform, div 0, 8N1, 0xA5 ----
        pat = 8'hA5;
        tx_data_i = pat;
        tx_valid_i = 1'b1;
        cycles(1);
        tx_valid_i = 1'b0;
        n = 0;
        while (tx_o !== 1'b0 && n < 50) begin
            cycles(1);
            n++;
        end
        check("tx_start_low", tx_o, 0);
        check("tx_busy_at_start", tx_busy_o, 1);
        cycles(8);
        check("tx_start_mid", tx_o, 0);
        for (int i = 0; i < 8; i++) begin
            cycles(16);
            check($sformatf("tx_bit%0d", i), tx_o, pat[i]);
        end
        cycles(16);
        check("tx_stop", tx_o, 1);
        n = 0;
        while (tx_busy_o === 1'b1 && n < 400) begin
            cycles(1);
            n++;
        end
        check("tx_busy_len", 152 + n, 160);
        check("tx_idle_high", tx_o, 1);

        // ---- loopback, div 3, 7 bits, odd parity, 2 stop ----
        cfg_div_i = 16'd3;
        cfg_data_bits_i = 2'd2;
        cfg_parity_en_i = 1'b1;
        cfg_parity_type_i = 1'b1;
        cfg_stop_bits_i = 1'b1;
        loop_en = 1'b1;
        cycles(2);
        tx_valid_i = 1'b1;
        tx_data_i = 8'h55;
        cycles(1);
        tx_data_i = 8'h7F;
        cycles(1);
        tx_valid_i = 1'b0;
        n = 0;
        while (rx_count_o !== 5'd2 && n < 4000) begin
            cycles(1);
            n++;
        end
        check("loop_rx_count", rx_count_o, 2);
        check("loop_byte0", rx_data_o, 8'h55);
        pop_rx();
        check("loop_byte1", rx_data_o, 8'h7F);
        pop_rx();
        check("loop_rx_empty", rx_valid_o, 0);
        check("loop_no_errors", par_cnt + frm_cnt + ovr_cnt, 0);
        n = 0;
        while (tx_busy_o === 1'b1 && n < 2000) begin
            cycles(1);
            n++;
        end
        check("loop_tx_done", tx_busy_o, 0);
        loop_en = 1'b0;
        rx_drv = 1'b1;
        cycles(100);

        // ---- parity error: 0x3C, 8 bits, even parity, flipped parity bit ----
        cfg_data_bits_i = 2'd3;
        cfg_parity_type_i = 1'b0;
        cfg_stop_bits_i = 1'b0;
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 64);
        cycles(10);
        check("par_rx_count", rx_count_o, 1);
        check("par_rx_data", rx_data_o, 8'h3C);
        check("par_pulse_count", par_cnt, 1);
        check("par_no_frame_err", frm_cnt, 0);
        pop_rx();

        // ---- framing error: stop bit low, then line held low (break) ----
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 64);
        cycles(600);
        check("frm_pulse_count", frm_cnt, 1);
        check("frm_discarded", rx_count_o, 0);
        rx_drv = 1'b1;
        cycles(100);
        check("frm_break_no_frames", frm_cnt, 1);
        check("frm_break_rx_count", rx_count_o, 0);
        send_frame(8'hC3, 8, 1'b1, 1'b0, 1'b1, 64);
        cycles(10);
        check("frm_recover_data", rx_data_o, 8'hC3);
        check("frm_recover_count", rx_count_o, 1);
        check("frm_recover_par", par_cnt, 1);
        pop_rx();

        // ---- one-tick low glitch, 8N1 ----
        cfg_parity_en_i = 1'b0;
        cycles(20);
        rx_drv = 1'b0;
        cycles(4);
        rx_drv = 1'b1;
        cycles(200);
        check("glitch_no_byte", rx_count_o, 0);
        check("glitch_no_errors", {par_cnt[7:0], frm_cnt[7:0], ovr_cnt[7:0]}, {8'd1, 8'd1, 8'd0});
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, 64);
        cycles(10);
        check("glitch_then_byte", rx_data_o, 8'h5A);
        pop_rx();

        // ---- RX overrun at div 0 ----
        cfg_div_i = 16'd0;
        cycles(20);
        for (int i = 0; i < 16; i++) send_frame(8'h40 + 8'(i), 8, 1'b0, 1'b0, 1'b1, 16);
        cycles(5);
        check("ovr_full_count", rx_count_o, 16);
        check("ovr_none_yet", ovr_cnt, 0);
        send_frame(8'hEE, 8, 1'b0, 1'b0, 1'b1, 16);
        cycles(5);
        check("ovr_count_held", rx_count_o, 16);
        check("ovr_pulse_count", ovr_cnt, 1);
        check("ovr_head", rx_data_o, 8'h40);
        rx_flush_i = 1'b1;
        cycles(1);
        rx_flush_i = 1'b0;
        check("rx_flush_count", rx_count_o, 0);

        // ---- TX fill and flush ----
        cfg_div_i = 16'd1000;
        tx_data_i = 8'h81;
        tx_valid_i = 1'b1;
        cycles(1);
        tx_valid_i = 1'b0;
        n = 0;
        while (tx_busy_o !== 1'b1 && n < 1200) begin
            cycles(1);
            n++;
        end
        check("fill_frame_started", tx_busy_o, 1);
        cfg_div_i = 16'd3;
        for (int i = 0; i < 16; i++) begin
            tx_valid_i = 1'b1;
            tx_data_i = 8'(i);
            cycles(1);
        end
        tx_valid_i = 1'b0;
        check("fill_tx_count", tx_count_o, 16);
        check("fill_tx_ready", tx_ready_o, 0);
        tx_valid_i = 1'b1;
        tx_data_i = 8'hFF;
        tx_flush_i = 1'b1;
        cycles(1);
        tx_valid_i = 1'b0;
        tx_flush_i = 1'b0;
        check("flush_tx_count", tx_count_o, 0);
        check("flush_tx_ready", tx_ready_o, 1);
        check("flush_frame_continues", tx_busy_o, 1);
        n = 0;
        while (tx_busy_o === 1'b1 && n < 1000) begin
            cycles(1);
            n++;
        end
        check("flush_frame_done", tx_busy_o, 0);
        cycles(300);
        check("flush_no_more_frames", {tx_busy_o, tx_o}, 2'b01);
        check("flush_count_stays", tx_count_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
